// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive-side monitor for a time-multiplexed 8-digit seven-segment display.
// Watches the active-low anode/segment bus and recovers the 32-bit hex value
// on show, one nibble per digit. A digit is latched only after its
// {anodes, segments} sample has been stable for STABLE_CYCLES consecutive
// edges, which filters scan transitions and glitches. At most one latch
// happens per stable dwell.
//
// Optional feature macro: SEG_SCAN_SYNC_EN
//   When defined, a two-flop synchronizer (reset to blank, all ones) sits in
//   front of the input register. All latencies grow by two cycles.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples before a latch (1..255)
//   DIGIT_MASK     digits that must be captured to complete a frame
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   anodes       digit enables, active-low, bit i = digit i
//   segments     segment lines, active-low, bit0=a ... bit6=g
//   clear_err    synchronous clear of the sticky error flags
//   hex_out      recovered value, nibble i = digit i
//   digit_valid  bit i = nibble i holds a successfully decoded pattern
//   frame_done   one-cycle pulse when all DIGIT_MASK digits were captured
//   anode_err    sticky: two or more anodes low during a stable dwell
//   seg_err      sticky: an undecodable segment pattern was latched
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  DIGIT_MASK    = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  anodes,
    input  logic [6:0]  segments,
    input  logic        clear_err,
    output logic [31:0] hex_out,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        anode_err,
    output logic        seg_err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic {
        TRACK = 1'b0,
        HELD  = 1'b1
    } state_t;

    // Decode an active-low gfedcba pattern. Returns {legal, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- input
    logic [14:0] bus_in;

`ifdef SEG_SCAN_SYNC_EN
    logic [14:0] sync1_q;
    logic [14:0] sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {anodes, segments};
            sync2_q <= sync1_q;
        end
    end

    assign bus_in = sync2_q;
`else
    assign bus_in = {anodes, segments};
`endif

    // -------------------------------------------------------------- state
    logic [14:0] sample_q;
    logic [14:0] prev_q;
    logic        vld_q;       // sample_q holds a real sample since reset
    logic [7:0]  cnt_q,   cnt_d;
    state_t      state_q, state_d;
    logic [31:0] hex_q,   hex_d;
    logic [7:0]  dv_q,    dv_d;
    logic [7:0]  seen_q,  seen_d;
    logic        frame_q, frame_d;
    logic        aerr_q,  aerr_d;
    logic        serr_q,  serr_d;

    // ---------------------------------------------------------- next state
    logic       changed;
    logic       latch;
    state_t     state_eff;
    logic [7:0] an_low;
    logic       one_low;
    logic       multi_low;
    logic [4:0] dec;
    logic       complete;

    always_comb begin
        changed   = (sample_q != prev_q);
        an_low    = ~sample_q[14:7];
        one_low   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        multi_low = (an_low != 8'h00) && !one_low;
        dec       = seg_decode(sample_q[6:0]);

        // Counter restarts at 1 on any change and saturates at STABLE_CYCLES.
        // Before the first real sample lands, the comparison is meaningless.
        if (!vld_q) begin
            cnt_d = 8'd0;
        end else if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= STABLE_C) begin
            cnt_d = STABLE_C;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // A change drops back to TRACK on the same edge, so with
        // STABLE_CYCLES=1 the new pattern can latch immediately.
        state_eff = changed ? TRACK : state_q;
        latch     = vld_q && (state_eff == TRACK) && (cnt_d == STABLE_C);
        state_d   = latch ? HELD : state_eff;

        hex_d  = hex_q;
        dv_d   = dv_q;
        aerr_d = clear_err ? 1'b0 : aerr_q;
        serr_d = clear_err ? 1'b0 : serr_q;

        // Completion clears seen on the pulse edge; a latch on that same
        // edge still registers its digit for the next frame.
        complete = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
        frame_d  = complete;
        seen_d   = complete ? 8'h00 : seen_q;

        if (latch) begin
            if (multi_low) begin
                aerr_d = 1'b1;
            end else if (one_low) begin
                for (int i = 0; i < 8; i++) begin
                    if (an_low[i]) begin
                        if (dec[4]) begin
                            hex_d[4*i +: 4] = dec[3:0];
                            dv_d[i]         = 1'b1;
                            seen_d[i]       = 1'b1;
                        end else begin
                            dv_d[i] = 1'b0;
                            serr_d  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
            prev_q   <= '0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= TRACK;
            hex_q    <= '0;
            dv_q     <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            aerr_q   <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            sample_q <= bus_in;
            prev_q   <= sample_q;
            vld_q    <= 1'b1;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hex_q    <= hex_d;
            dv_q     <= dv_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            aerr_q   <= aerr_d;
            serr_q   <= serr_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = dv_q;
    assign frame_done  = frame_q;
    assign anode_err   = aerr_q;
    assign seg_err     = serr_q;

endmodule
